// File: rtl/ctl_unit_seq.sv
// Multi-cycle RV32I control sequencer: owns PC/IR, drives one req/ack memory port
// shared by fetch and load/store, and latches sticky traps.
module ctl_unit_seq #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] alu_result,
    input  logic        br_taken,
    input  logic [31:0] rs2_data,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        rf_we,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    // A zero-width counter is not legal, so keep at least one bit when timeout is disabled.
    localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;
    localparam logic [CNT_W-1:0] TO_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      next_pc_q, next_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;

    logic [6:0]  opcode;
    logic        legal;
    logic [31:0] exec_pc;
    logic [31:0] pc_plus4;

    assign opcode   = ir_q[6:0];
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: legal = (ir_q[1:0] == 2'b11);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        exec_pc = pc_plus4;
        case (opcode)
            OP_BRANCH: exec_pc = br_taken ? alu_result : pc_plus4;
            OP_JAL:    exec_pc = alu_result;
            OP_JALR:   exec_pc = {alu_result[31:1], 1'b0};
            default:   exec_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        next_pc_d = next_pc_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        rf_we     = 1'b0;
        retire    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!legal) begin
                    state_d = ST_TRAP;
                    cause_d = 2'd1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_pc[1:0] != 2'b00) begin
                    state_d = ST_TRAP;
                    cause_d = 2'd3;
                end else begin
                    next_pc_d = exec_pc;
                    if (opcode == OP_LOAD || opcode == OP_STORE) begin
                        state_d = ST_MEM;
                    end else if (opcode == OP_BRANCH) begin
                        retire  = 1'b1;
                        pc_d    = exec_pc;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_addr = alu_result;
                mem_we   = (opcode == OP_STORE);
                if (mem_ack) begin
                    if (opcode == OP_STORE) begin
                        retire  = 1'b1;
                        pc_d    = next_pc_q;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                pc_d    = next_pc_q;
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase

        // Ack in the expiring cycle completes the transfer instead of trapping.
        if (MEM_TIMEOUT != 0 && mem_req && !mem_ack && cnt_q == TO_LAST) begin
            state_d = ST_TRAP;
            cause_d = 2'd2;
        end

        if (state_d != state_q || mem_ack) begin
            cnt_d = '0;
        end else if (mem_req) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (sys_rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            rf_we   = 1'b0;
            retire  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0000_0013;
            next_pc_q <= RESET_PC;
            cnt_q     <= '0;
            cause_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            next_pc_q <= next_pc_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
        end
    end

    assign mem_wdata  = rs2_data;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_ctl_unit_seq.sv
// Directed bench for ctl_unit_seq; DUT built with MEM_TIMEOUT=4 so the timeout
// boundary is reachable in a few cycles.
module tb_ctl_unit_seq;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        mem_ack = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] rs2_data = 32'h0;

    logic        mem_req, mem_we, rf_we, retire, trap;
    logic [31:0] mem_addr, mem_wdata, pc, ir;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] I_ADDI = 32'h0010_0093;
    localparam logic [31:0] I_LW   = 32'h0000_2083;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_SW   = 32'h0020_2023;
    localparam logic [31:0] I_JALR = 32'h0000_80E7;

    ctl_unit_seq #(
        .RESET_PC    (32'h0000_0000),
        .MEM_TIMEOUT (4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .alu_result (alu_result),
        .br_taken   (br_taken),
        .rs2_data   (rs2_data),
        .pc         (pc),
        .ir         (ir),
        .rf_we      (rf_we),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state      (state)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Holds reset for one edge with a stray ack present, then releases it right after the edge.
    task automatic test_reset;
        @(negedge sys_clk); sys_rst = 1'b1; mem_ack = 1'b1; mem_rdata = I_ADDI; #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %0b want 0", mem_req); end
        n_cmp++; if (retire !== 1'b0) begin n_fail++; $display("FAIL rst_retire got %0b want 0", retire); end
        @(posedge sys_clk); #1;
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", state); end
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 00000000", pc); end
        n_cmp++; if (ir !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_ir got %h want 00000013", ir); end
        n_cmp++; if (trap !== 1'b0 || trap_cause !== 2'd0) begin n_fail++; $display("FAIL rst_trap got %0b/%0d want 0/0", trap, trap_cause); end
        sys_rst = 1'b0; mem_ack = 1'b0;
        $display("reset: state=%0d pc=%h ir=%h", state, pc, ir);
    endtask

    task automatic test_addi;
        @(negedge sys_clk); mem_ack = 1'b1; mem_rdata = I_ADDI; #1;
        n_cmp++; if (state !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL addi_fetch got st=%0d req=%0b addr=%h want 0/1/00000000", state, mem_req, mem_addr); end
        @(negedge sys_clk); mem_ack = 1'b0; #1;
        n_cmp++; if (state !== 3'd1 || ir !== I_ADDI || mem_req !== 1'b0) begin n_fail++; $display("FAIL addi_decode got st=%0d ir=%h req=%0b want 1/%h/0", state, ir, mem_req, I_ADDI); end
        @(negedge sys_clk); #1;
        n_cmp++; if (state !== 3'd2 || retire !== 1'b0) begin n_fail++; $display("FAIL addi_exec got st=%0d ret=%0b want 2/0", state, retire); end
        @(negedge sys_clk); #1;
        n_cmp++; if (state !== 3'd4 || rf_we !== 1'b1 || retire !== 1'b1) begin n_fail++; $display("FAIL addi_wb got st=%0d we=%0b ret=%0b want 4/1/1", state, rf_we, retire); end
        @(posedge sys_clk); #1;
        n_cmp++; if (pc !== 32'h4 || state !== 3'd0 || trap !== 1'b0) begin n_fail++; $display("FAIL addi_done got pc=%h st=%0d trap=%0b want 00000004/0/0", pc, state, trap); end
        $display("addi: pc=%h state=%0d", pc, state);
    endtask

    // Data ack lands on the 4th request cycle: the timeout boundary where ack must win.
    task automatic test_load;
        @(negedge sys_clk); mem_ack = 1'b1; mem_rdata = I_LW; #1;
        n_cmp++; if (mem_addr !== 32'h4) begin n_fail++; $display("FAIL lw_fetch_addr got %h want 00000004", mem_addr); end
        @(negedge sys_clk); mem_ack = 1'b0; #1;
        @(negedge sys_clk); alu_result = 32'h200; #1;
        n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL lw_exec_state got %0d want 2", state); end
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk); mem_ack = (i == 3); mem_rdata = 32'hCAFE_0000; #1;
            n_cmp++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0 || retire !== 1'b0) begin
                n_fail++; $display("FAIL lw_mem%0d got st=%0d req=%0b addr=%h we=%0b ret=%0b want 3/1/00000200/0/0", i, state, mem_req, mem_addr, mem_we, retire);
            end
        end
        @(negedge sys_clk); mem_ack = 1'b0; #1;
        n_cmp++; if (state !== 3'd4 || rf_we !== 1'b1 || retire !== 1'b1) begin n_fail++; $display("FAIL lw_wb got st=%0d we=%0b ret=%0b want 4/1/1", state, rf_we, retire); end
        @(posedge sys_clk); #1;
        n_cmp++; if (pc !== 32'h8 || trap !== 1'b0) begin n_fail++; $display("FAIL lw_done got pc=%h trap=%0b want 00000008/0", pc, trap); end
        $display("lw: pc=%h trap=%0b", pc, trap);
    endtask

    task automatic test_branch;
        @(negedge sys_clk); mem_ack = 1'b1; mem_rdata = I_BEQ; #1;
        @(negedge sys_clk); mem_ack = 1'b0; #1;
        @(negedge sys_clk); br_taken = 1'b1; alu_result = 32'h100; #1;
        n_cmp++; if (state !== 3'd2 || retire !== 1'b1 || rf_we !== 1'b0) begin n_fail++; $display("FAIL beq_exec got st=%0d ret=%0b we=%0b want 2/1/0", state, retire, rf_we); end
        @(posedge sys_clk); #1;
        n_cmp++; if (pc !== 32'h100 || state !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL beq_taken got pc=%h st=%0d req=%0b addr=%h want 00000100/0/1/00000100", pc, state, mem_req, mem_addr); end
        $display("beq taken: pc=%h", pc);
        @(negedge sys_clk); mem_ack = 1'b1; mem_rdata = I_BEQ; #1;
        @(negedge sys_clk); mem_ack = 1'b0; #1;
        @(negedge sys_clk); alu_result = 32'h102; #1;
        n_cmp++; if (retire !== 1'b0) begin n_fail++; $display("FAIL beq_mis_retire got %0b want 0", retire); end
        @(posedge sys_clk); #1;
        n_cmp++; if (state !== 3'd5 || trap !== 1'b1 || trap_cause !== 2'd3 || pc !== 32'h100 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL beq_mis_trap got st=%0d trap=%0b cause=%0d pc=%h req=%0b want 5/1/3/00000100/0", state, trap, trap_cause, pc, mem_req);
        end
        br_taken = 1'b0;
        $display("beq misaligned: trap=%0b cause=%0d pc=%h", trap, trap_cause, pc);
    endtask

    task automatic test_illegal;
        @(negedge sys_clk); mem_ack = 1'b1; mem_rdata = 32'h0; #1;
        @(negedge sys_clk); mem_ack = 1'b0; #1;
        n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL ill_decode got %0d want 1", state); end
        @(posedge sys_clk); #1;
        n_cmp++; if (state !== 3'd5 || trap !== 1'b1 || trap_cause !== 2'd1) begin n_fail++; $display("FAIL ill_trap got st=%0d trap=%0b cause=%0d want 5/1/1", state, trap, trap_cause); end
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk); mem_ack = i[0]; mem_rdata = I_ADDI; #1;
            n_cmp++; if (mem_req !== 1'b0 || retire !== 1'b0 || trap !== 1'b1) begin n_fail++; $display("FAIL ill_hold%0d got req=%0b ret=%0b trap=%0b want 0/0/1", i, mem_req, retire, trap); end
        end
        mem_ack = 1'b0;
        @(posedge sys_clk); #1;
        n_cmp++; if (pc !== 32'h0 || ir !== 32'h0 || trap_cause !== 2'd1) begin n_fail++; $display("FAIL ill_frozen got pc=%h ir=%h cause=%0d want 00000000/00000000/1", pc, ir, trap_cause); end
        $display("illegal: trap=%0b cause=%0d", trap, trap_cause);
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk); mem_ack = 1'b0; #1;
            n_cmp++; if (trap !== 1'b0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL to_wait%0d got trap=%0b req=%0b want 0/1", i, trap, mem_req); end
        end
        @(posedge sys_clk); #1;
        n_cmp++; if (state !== 3'd5 || trap !== 1'b1 || trap_cause !== 2'd2 || mem_req !== 1'b0) begin n_fail++; $display("FAIL to_trap got st=%0d trap=%0b cause=%0d req=%0b want 5/1/2/0", state, trap, trap_cause, mem_req); end
        $display("timeout: trap=%0b cause=%0d", trap, trap_cause);
    endtask

    task automatic test_timeout_ack;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk); mem_ack = (i == 3); mem_rdata = I_ADDI; #1;
        end
        @(posedge sys_clk); #1;
        n_cmp++; if (state !== 3'd1 || trap !== 1'b0 || ir !== I_ADDI) begin n_fail++; $display("FAIL to_ack got st=%0d trap=%0b ir=%h want 1/0/%h", state, trap, ir, I_ADDI); end
        mem_ack = 1'b0;
        repeat (3) @(negedge sys_clk);
        @(posedge sys_clk); #1;
        n_cmp++; if (pc !== 32'h4 || state !== 3'd0) begin n_fail++; $display("FAIL to_ack_done got pc=%h st=%0d want 00000004/0", pc, state); end
        $display("timeout ack-wins: pc=%h trap=%0b", pc, trap);
    endtask

    // Store completes and the port goes straight to the next fetch without dropping mem_req.
    task automatic test_back_to_back;
        @(negedge sys_clk); mem_ack = 1'b1; mem_rdata = I_SW; #1;
        @(negedge sys_clk); mem_ack = 1'b0; #1;
        @(negedge sys_clk); alu_result = 32'h300; rs2_data = 32'hDEAD_BEEF; #1;
        @(negedge sys_clk); mem_ack = 1'b1; #1;
        n_cmp++; if (state !== 3'd3 || mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'hDEAD_BEEF || retire !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL sw_mem got st=%0d we=%0b addr=%h wd=%h ret=%0b rf=%0b want 3/1/00000300/deadbeef/1/0", state, mem_we, mem_addr, mem_wdata, retire, rf_we);
        end
        @(posedge sys_clk); #1;
        mem_ack = 1'b0; #1;
        n_cmp++; if (state !== 3'd0 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h8 || pc !== 32'h8) begin
            n_fail++; $display("FAIL sw_next got st=%0d req=%0b we=%0b addr=%h pc=%h want 0/1/0/00000008/00000008", state, mem_req, mem_we, mem_addr, pc);
        end
        $display("sw: pc=%h mem_addr=%h", pc, mem_addr);
    endtask

    task automatic test_reset_mid_store;
        @(negedge sys_clk); mem_ack = 1'b1; mem_rdata = I_SW; #1;
        @(negedge sys_clk); mem_ack = 1'b0; #1;
        @(negedge sys_clk); alu_result = 32'h304; #1;
        @(negedge sys_clk); sys_rst = 1'b1; mem_ack = 1'b1; #1;
        n_cmp++; if (retire !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid got ret=%0b req=%0b we=%0b want 0/0/0", retire, mem_req, mem_we); end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0; mem_ack = 1'b0; #1;
        n_cmp++; if (pc !== 32'h0 || state !== 3'd0 || trap !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after got pc=%h st=%0d trap=%0b want 00000000/0/0", pc, state, trap); end
        $display("reset mid-store: pc=%h state=%0d", pc, state);
    endtask

    task automatic test_jalr;
        @(negedge sys_clk); mem_ack = 1'b1; mem_rdata = I_JALR; #1;
        @(negedge sys_clk); mem_ack = 1'b0; #1;
        @(negedge sys_clk); alu_result = 32'h21; #1;
        @(negedge sys_clk); #1;
        n_cmp++; if (state !== 3'd4 || rf_we !== 1'b1 || retire !== 1'b1) begin n_fail++; $display("FAIL jalr_wb got st=%0d we=%0b ret=%0b want 4/1/1", state, rf_we, retire); end
        @(posedge sys_clk); #1;
        n_cmp++; if (pc !== 32'h20 || trap !== 1'b0) begin n_fail++; $display("FAIL jalr_pc got pc=%h trap=%0b want 00000020/0", pc, trap); end
        $display("jalr: pc=%h", pc);
    endtask

    initial begin
        test_reset;
        test_addi;
        test_load;
        test_branch;
        test_reset;
        test_illegal;
        test_reset;
        test_timeout;
        test_reset;
        test_timeout_ack;
        test_back_to_back;
        test_reset_mid_store;
        test_jalr;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
